bcd3_to_bin: RTL and testbench

Sequential 3-digit BCD-to-binary converter using reverse double-dabble (shift-right, subtract-3). It accepts a 12-bit packed BCD value (000–999), such as the sum output of the team's 3-digit BCD adder, and returns the equivalent 10-bit unsigned binary value. It is the decode direction for the BCD datapath and feeds binary consumers such as comparators and counters. It uses a start/busy/done handshake and flags non-decimal digits.

---
 rtl/bcd3_to_bin_if.sv | 33 +++
 rtl/bcd3_to_bin.sv | 111 +++++++++++
 tb/tb_bcd3_to_bin.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/bcd3_to_bin_if.sv
`default_nettype none
// ============================================================================
// Module   : bcd3_to_bin_if
// Purpose  : Start/busy/done handshake bundle for the 3-digit BCD decoder.
// Revision : 1.0  initial release
// ============================================================================
interface bcd3_to_bin_if;
    logic        start;
    logic [11:0] bcd_in;
    logic        busy;
    logic        done;
    logic [9:0]  bin_out;
    logic        err;

    modport master (
        output start,
        output bcd_in,
        input  busy,
        input  done,
        input  bin_out,
        input  err
    );

    modport slave (
        input  start,
        input  bcd_in,
        output busy,
        output done,
        output bin_out,
        output err
    );
endinterface
`default_nettype wire

// File: rtl/bcd3_to_bin.sv
`default_nettype none
// ============================================================================
// Module   : bcd3_to_bin
// Purpose  : Sequential 3-digit BCD to 10-bit binary, reverse double-dabble.
// Revision : 1.0  initial release
// ============================================================================
module bcd3_to_bin (
    input  wire            clk,
    input  wire            rst,
    bcd3_to_bin_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [3:0] LAST_COUNT = 4'd9;

    state_t      state;
    logic [11:0] bcd_reg;
    logic [9:0]  bin_reg;
    logic [3:0]  count;
    logic        busy;
    logic        done;
    logic [9:0]  bin_out;
    logic        err;

    logic [21:0] shifted;
    logic [11:0] shifted_bcd;
    logic [9:0]  shifted_bin;
    logic [11:0] adjusted_bcd;
    logic        bad_digit;

    function automatic logic [3:0] adjust_digit(input logic [3:0] d);
        return (d >= 4'd8) ? (d - 4'd3) : d;
    endfunction

    always_comb begin
        shifted      = {bcd_reg, bin_reg} >> 1;
        shifted_bcd  = shifted[21:10];
        shifted_bin  = shifted[9:0];
        adjusted_bcd = {adjust_digit(shifted_bcd[11:8]),
                        adjust_digit(shifted_bcd[7:4]),
                        adjust_digit(shifted_bcd[3:0])};
        bad_digit    = (bus.bcd_in[11:8] > 4'd9) ||
                       (bus.bcd_in[7:4]  > 4'd9) ||
                       (bus.bcd_in[3:0]  > 4'd9);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            bcd_reg <= 12'd0;
            bin_reg <= 10'd0;
            count   <= 4'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bin_out <= 10'd0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                // The edge that closes the done cycle also accepts a new
                // request, giving back-to-back conversions every 11 cycles.
                IDLE, DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                    if (bus.start) begin
                        bcd_reg <= bus.bcd_in;
                        bin_reg <= 10'd0;
                        count   <= 4'd0;
                        err     <= 1'b0;
                        if (bad_digit) begin
                            err     <= 1'b1;
                            bin_out <= 10'd0;
                            done    <= 1'b1;
                            state   <= DONE;
                        end else begin
                            busy  <= 1'b1;
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    bcd_reg <= adjusted_bcd;
                    bin_reg <= shifted_bin;
                    count   <= count + 4'd1;
                    if (count == LAST_COUNT) begin
                        bin_out <= shifted_bin;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.bin_out = bin_out;
    assign bus.err     = err;

endmodule
`default_nettype wire

// File: tb/tb_bcd3_to_bin.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd3_to_bin
// Purpose  : Self-checking bench for bcd3_to_bin against a decimal model.
// Revision : 1.0  initial release
// ============================================================================
module tb_bcd3_to_bin;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;

    bcd3_to_bin_if bus ();

    bcd3_to_bin dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: decimal value of the digits, error if any digit exceeds 9.
    function automatic int ref_val(input logic [11:0] v);
        return 100 * int'(v[11:8]) + 10 * int'(v[7:4]) + int'(v[3:0]);
    endfunction

    function automatic bit ref_bad(input logic [11:0] v);
        return (v[11:8] > 9) || (v[7:4] > 9) || (v[3:0] > 9);
    endfunction

    task automatic convert(input logic [11:0] v);
        int lat;
        int busy_cnt;
        bit bad;
        bad = ref_bad(v);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = v;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.bcd_in = 12'($urandom);
        chk("err_at_accept", bus.err, bad);
        lat = 0;
        busy_cnt = 0;
        while (bus.done !== 1'b1 && lat < 20) begin
            busy_cnt += (bus.busy === 1'b1) ? 1 : 0;
            @(posedge clk);
            #1;
            lat++;
        end
        chk("latency", lat, bad ? 0 : 10);
        chk("busy_cycles", busy_cnt, bad ? 0 : 10);
        chk("busy_at_done", bus.busy, 1'b0);
        chk("bin_out", bus.bin_out, bad ? 0 : ref_val(v));
        chk("err", bus.err, bad);
        @(posedge clk);
        #1;
        chk("done_width", bus.done, 1'b0);
    endtask

    initial begin
        logic [11:0] v;
        n_vec      = 0;
        n_err      = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.bcd_in = 12'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_bin", bus.bin_out, 10'd0);
        chk("rst_err", bus.err, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        convert(12'h999);
        convert(12'h000);
        convert(12'h010);
        convert(12'h555);
        convert(12'h0A5);
        convert(12'h123);

        // Request during SHIFT is ignored; held start is taken at E+11.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = 12'h321;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        bus.start  = 1'b1;
        bus.bcd_in = 12'h999;
        repeat (7) @(posedge clk);
        #1;
        chk("ign_done", bus.done, 1'b1);
        chk("ign_bin", bus.bin_out, 10'd321);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        chk("b2b_busy", bus.busy, 1'b1);
        chk("b2b_done", bus.done, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("b2b_done2", bus.done, 1'b1);
        chk("b2b_bin", bus.bin_out, 10'd999);

        // Asynchronous reset mid-conversion.
        @(negedge clk);
        bus.start  = 1'b1;
        bus.bcd_in = 12'h876;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_busy", bus.busy, 1'b0);
        chk("arst_done", bus.done, 1'b0);
        chk("arst_bin", bus.bin_out, 10'd0);
        chk("arst_err", bus.err, 1'b0);
        repeat (8) begin
            @(posedge clk);
            #1;
            chk("arst_no_done", bus.done, 1'b0);
        end
        @(negedge clk);
        rst = 1'b0;
        convert(12'h042);

        for (int h = 0; h < 10; h++)
            for (int t = 0; t < 10; t++)
                for (int u = 0; u < 10; u++)
                    convert({h[3:0], t[3:0], u[3:0]});

        repeat (200) begin
            if ($urandom_range(0, 3) != 0)
                v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            else
                v = 12'($urandom);
            convert(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
